// File: rtl/div_seq_32.sv
// div_seq_32: iterative restoring divider, one quotient bit per clock.
// Operands are reduced to magnitudes on accept, divided unsigned, and the
// signs are reapplied in a final fix-up cycle before done is raised.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH+1:0] ONE_X = (WIDTH + 2)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;

  logic             dvd_neg_in;
  logic             dvsr_neg_in;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvsr_mag_in;
  logic [WIDTH+1:0] r_ext;
  logic [WIDTH+1:0] sub_ext;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Operand magnitudes and one shift-subtract step; the subtract is a + ~b + 1
  // widened by one bit so the top bit of the result reads directly as the borrow.
  always_comb begin
    dvd_neg_in  = signed_op & dividend[WIDTH-1];
    dvsr_neg_in = signed_op & divisor[WIDTH-1];
    dvd_mag_in  = dvd_neg_in  ? (~dividend + ONE_W) : dividend;
    dvsr_mag_in = dvsr_neg_in ? (~divisor  + ONE_W) : divisor;
    r_ext       = {rem_acc, quo_acc[WIDTH-1]};
    sub_ext     = r_ext + ~{2'b00, dvsr_mag} + ONE_X;
    borrow      = sub_ext[WIDTH+1];
    rem_next    = borrow ? r_ext[WIDTH:0] : sub_ext[WIDTH:0];
    quo_next    = {quo_acc[WIDTH-2:0], ~borrow};
  end

  // Control FSM and datapath registers; divide-by-zero spends a single CALC
  // cycle so its done lands at a fixed short latency of its own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      dvsr_mag    <= '0;
      dvd_raw     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            dvd_raw     <= dividend;
            dvsr_mag    <= dvsr_mag_in;
            quo_acc     <= dvd_mag_in;
            rem_acc     <= '0;
            neg_q       <= dvd_neg_in ^ dvsr_neg_in;
            neg_r       <= dvd_neg_in;
            zero_div    <= (divisor == '0);
            count       <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
            state       <= CALC;
          end
        end
        CALC: begin
          rem_acc <= rem_next;
          quo_acc <= quo_next;
          count   <= count - 1'b1;
          if (count == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= neg_q ? (~quo_acc + ONE_W) : quo_acc;
            remainder   <= neg_r ? (~rem_acc[WIDTH-1:0] + ONE_W) : rem_acc[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: directed scoreboard bench for div_seq_32.
// Stimulus pushes hand-computed results; a negedge monitor pops on done.
module tb_div_seq_32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   edge_count = 0;
  int   vectors = 0;
  int   miscompares = 0;

  div_seq_32 #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 10 time-unit clock
  always #5 clock = ~clock;

  // Running index of rising edges, used to measure start-to-done latency
  always @(posedge clock) edge_count++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge; drives one request across the next edge
  task automatic applyStimulus(input logic sop, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er, input logic edz,
                               input bit push);
    exp_t e;
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.lat = edz ? 3 : 34;
      e.acc = edge_count;
      sb.push_back(e);
    end
    @(negedge clock);
    start     = 1'b0;
    signed_op = $urandom_range(0, 1);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic waitIdle();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL busy_timeout: busy=%0b after 100 cycles, expected 0", busy);
    end
    @(negedge clock);
  endtask

  task automatic waitDone();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: done=%0b after 100 cycles, expected 1", done);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        checkOutput("latency", 32'(edge_count - e.acc + 1), 32'(e.lat));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_quotient", quotient, 32'h0);
    checkOutput("reset_remainder", remainder, 32'h0);
    checkOutput("reset_dz", {31'b0, div_by_zero}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic unsigned, signed sign combinations, divide-by-zero, extremes
    @(negedge clock); applyStimulus(0, 32'd100,      32'd7,          32'd14,       32'd2,        0, 1); waitIdle();
    @(negedge clock); applyStimulus(1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1); waitIdle();
    @(negedge clock); applyStimulus(1, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2, 32'd2,        0, 1); waitIdle();
    @(negedge clock); applyStimulus(1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,       32'hFFFFFFFE, 0, 1); waitIdle();
    @(negedge clock); applyStimulus(0, 32'h12345678, 32'd0,          32'hFFFFFFFF, 32'h12345678, 1, 1); waitIdle();
    @(negedge clock); applyStimulus(1, 32'hFFFFFF9C, 32'd0,          32'hFFFFFFFF, 32'hFFFFFF9C, 1, 1); waitIdle();
    @(negedge clock); applyStimulus(1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'd0,        0, 1); waitIdle();
    @(negedge clock); applyStimulus(0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF, 32'd0,        0, 1); waitIdle();
    @(negedge clock); applyStimulus(0, 32'd5,        32'd9,          32'd0,        32'd5,        0, 1); waitIdle();
    @(negedge clock); applyStimulus(0, 32'hFFFFFFFF, 32'h10,         32'h0FFFFFFF, 32'hF,        0, 1); waitIdle();

    // start while busy must be ignored
    @(negedge clock); applyStimulus(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
    repeat (9) @(negedge clock);
    start = 1'b1; signed_op = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clock);
    start = 1'b0;
    waitIdle();

    // Back-to-back: second start driven during the done cycle
    @(negedge clock); applyStimulus(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 1);
    waitDone();
    applyStimulus(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0, 1);
    waitIdle();

    // Reset mid-CALC aborts with outputs cleared and no done pulse
    @(negedge clock); applyStimulus(0, 32'hDEADBEEF, 32'd3, 32'd0, 32'd0, 0, 0);
    repeat (13) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    checkOutput("abort_done", {31'b0, done}, 32'h0);
    checkOutput("abort_quotient", quotient, 32'h0);
    checkOutput("abort_remainder", remainder, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    applyStimulus(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 1);
    waitIdle();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending_results: got %0d outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
